// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: control-unit, core and HI/LO signals of the mult/div sequencer
interface muldiv_sequencer_if;
    logic        use_mult;
    logic        use_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        hi_wr;
    logic        lo_wr;
    logic [31:0] hilo_wdata;
    logic [31:0] opnd_a;
    logic [31:0] opnd_b;
    logic        mult_start;
    logic        mult_done;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;
    logic        div_start;
    logic        div_done;
    logic [31:0] div_rem;
    logic [31:0] div_quot;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        timeout;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    modport master (
        output use_mult, use_div, op_a, op_b, hi_wr, lo_wr, hilo_wdata,
        output mult_done, mult_hi, mult_lo, div_done, div_rem, div_quot,
        input  opnd_a, opnd_b, mult_start, div_start,
        input  busy, done, div_zero, timeout, hi_out, lo_out
    );
    modport slave (
        input  use_mult, use_div, op_a, op_b, hi_wr, lo_wr, hilo_wdata,
        input  mult_done, mult_hi, mult_lo, div_done, div_rem, div_quot,
        output opnd_a, opnd_b, mult_start, div_start,
        output busy, done, div_zero, timeout, hi_out, lo_out
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: launches one mult/div core per request, commits HI/LO, watchdogs the wait
module muldiv_sequencer #(
    parameter int TIMEOUT_CYCLES = 40
) (
    input logic               clock,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LAUNCH_M = 3'd1;
    localparam logic [2:0] LAUNCH_D = 3'd2;
    localparam logic [2:0] WAIT_M   = 3'd3;
    localparam logic [2:0] WAIT_D   = 3'd4;
    localparam logic [2:0] FINISH   = 3'd5;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d, opa_q, opa_d, opb_q, opb_d;
    logic          dz_q, dz_d, to_q, to_d;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        dz_d    = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                hi_d = bus.hi_wr ? bus.hilo_wdata : hi_q;
                lo_d = bus.lo_wr ? bus.hilo_wdata : lo_q;
                if (bus.use_mult || (bus.use_div && bus.op_b != '0)) begin
                    opa_d   = bus.op_a;
                    opb_d   = bus.op_b;
                    state_d = bus.use_mult ? LAUNCH_M : LAUNCH_D;
                end else begin
                    dz_d = bus.use_div;
                end
            end
            LAUNCH_M: begin
                cnt_d   = '0;
                state_d = WAIT_M;
            end
            LAUNCH_D: begin
                cnt_d   = '0;
                state_d = WAIT_D;
            end
            WAIT_M, WAIT_D: begin
                // a done landing on the last watchdog cycle still commits
                if (state_q == WAIT_M ? bus.mult_done : bus.div_done) begin
                    hi_d    = state_q == WAIT_M ? bus.mult_hi : bus.div_rem;
                    lo_d    = state_q == WAIT_M ? bus.mult_lo : bus.div_quot;
                    state_d = FINISH;
                end else if (cnt_q == LAST) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            dz_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            dz_q    <= dz_d;
            to_q    <= to_d;
        end
    end
    assign bus.opnd_a     = opa_q;
    assign bus.opnd_b     = opb_q;
    assign bus.mult_start = state_q == LAUNCH_M;
    assign bus.div_start  = state_q == LAUNCH_D;
    assign bus.busy       = state_q inside {LAUNCH_M, LAUNCH_D, WAIT_M, WAIT_D};
    assign bus.done       = state_q == FINISH;
    assign bus.div_zero   = dz_q;
    assign bus.timeout    = to_q;
    assign bus.hi_out     = hi_q;
    assign bus.lo_out     = lo_q;
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Sequences the iterative multiplier (booth_mult) and divider (booth_div) cores for the multicycle CPU.
- Accepts mult/div requests from control_Unit, latches operands from the A/B registers and launches exactly one core.
- Waits for that core's done signal, with a watchdog, then commits its results into HI/LO, which this block owns.
- Reports busy, done, division-by-zero and timeout to the control unit; also services mthi/mtlo writes.

Parameters:
TIMEOUT_CYCLES, 40, cycles allowed in a WAIT state before the watchdog aborts the operation (must be >= 2)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
use_mult  in  1  request pulse: signed multiply op_a*op_b
use_div  in  1  request pulse: signed divide op_a/op_b
op_a  in  32  operand A (RegA_Out)
op_b  in  32  operand B (RegB_Out)
hi_wr  in  1  mthi write enable
lo_wr  in  1  mtlo write enable
hilo_wdata  in  32  data for mthi/mtlo
opnd_a  out  32  latched operand A to both cores
opnd_b  out  32  latched operand B to both cores
mult_start  out  1  one-cycle start pulse to multiplier
mult_done  in  1  multiplier finished
mult_hi  in  32  product bits 63:32
mult_lo  in  32  product bits 31:0
div_start  out  1  one-cycle start pulse to divider
div_done  in  1  divider finished
div_rem  in  32  remainder (goes to HI)
div_quot  in  32  quotient (goes to LO)
busy  out  1  operation in flight; control unit stalls
done  out  1  one-cycle pulse: HI/LO committed
div_zero  out  1  one-cycle pulse: divide by zero rejected
timeout  out  1  one-cycle pulse: watchdog abort
hi_out  out  32  HI register
lo_out  out  32  LO register

Behaviour:
- Reset: one clock; reset is synchronous and active-high. On a reset edge the state goes to IDLE, and every output, the HI/LO registers, the operand latches and the watchdog counter become 0.
- Reset mid-operation: same result; any later core done is ignored.
- States: IDLE, LAUNCH_M, LAUNCH_D, WAIT_M, WAIT_D, FINISH.
- IDLE, request handling:
  - use_mult=1: latch op_a/op_b into opnd_a/opnd_b, go to LAUNCH_M.
  - use_div=1 with op_b!=0: latch operands, go to LAUNCH_D.
  - use_div=1 with op_b==0: no launch, no latch, HI/LO unchanged; div_zero=1 for the next cycle; stay in IDLE.
  - use_mult and use_div together: multiply wins; the divide request is dropped.
- IDLE, mthi/mtlo:
  - hi_wr writes HI and lo_wr writes LO with hilo_wdata at the edge; both may be set in the same cycle.
  - These writes are honoured in IDLE only and ignored in every other state.
  - An mthi/mtlo in the same cycle as a request is applied; the operation later overwrites HI/LO.
- LAUNCH_x:
  - busy=1.
  - Exactly one start pulse: mult_start in LAUNCH_M, div_start in LAUNCH_D.
  - Watchdog counter cleared to 0; next state is WAIT_x.
  - Any core done seen in LAUNCH is ignored.
- WAIT_x:
  - busy=1, start outputs 0, counter increments each cycle.
  - Done from the matching core: capture results at that edge (mult_hi/mult_lo, or div_rem/div_quot) into HI/LO; go to FINISH.
  - Done from the other core is ignored.
  - If the counter reaches TIMEOUT_CYCLES-1 without a done: timeout=1 for the next cycle, HI/LO unchanged, return to IDLE.
  - If done arrives in that same cycle, done wins.
- FINISH: busy=0, done=1 for one cycle, new HI/LO visible; next state is IDLE. Requests arriving in FINISH are ignored.
- Latency:
  - Request at cycle 0: busy from cycle 1 (LAUNCH); start pulse in cycle 1; WAIT from cycle 2.
  - Core done at cycle k: HI/LO updated and done pulse at cycle k+1; IDLE at k+2.
- Requests while busy are ignored; control_Unit must hold the instruction until busy falls.
- opnd_a/opnd_b hold their values from latch until the next accepted request.
- div_zero and timeout never coincide with done.

Test Plan:
- Multiply: op_a=7, op_b=0xFFFFFFFD, use_mult pulse; core returns mult_hi=0xFFFFFFFF, mult_lo=0xFFFFFFEB 33 cycles after start -> one mult_start pulse, busy high throughout, done pulse, hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB.
- Divide: op_a=17, op_b=5, use_div; core returns div_rem=2, div_quot=3 -> div_start only, mult_start never asserted, hi_out=2, lo_out=3, done one cycle.
- Divide by zero: op_b=0, use_div with HI=0x11, LO=0x22 -> div_zero pulse next cycle, no start, busy stays 0, HI/LO unchanged.
- Watchdog with TIMEOUT_CYCLES=40: launch multiply, never assert mult_done -> timeout pulse, state back to IDLE, HI/LO unchanged. Then assert mult_done -> no effect.
- Ignored inputs while busy: during WAIT_M pulse use_div, hi_wr (data 0xDEAD) and div_done -> all ignored; result comes only from mult_done. Simultaneous use_mult+use_div in IDLE -> only mult_start.
- Reset mid-operation: reset in WAIT_D -> next cycle all outputs 0, HI/LO 0. A later div_done -> no capture. A new use_mult afterwards completes normally.
